// File: rtl/body_scan_scheduler_pkg.sv
// Shared point/frame definitions for the snake body scan path and the pixel renderer.
// Holds point packing, LCD frame geometry defaults and the scan FSM state type.
package body_scan_scheduler_pkg;

    localparam int POINT_COORD_W  = 16;
    localparam int FRAME_H_PERIOD = 525;
    localparam int FRAME_V_PERIOD = 288;

    // x lives in the MSBs so a packed point_t matches the body array word layout
    typedef struct packed {
        logic [POINT_COORD_W-1:0] x;
        logic [POINT_COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    function automatic point_t make_point(input logic [POINT_COORD_W-1:0] x,
                                          input logic [POINT_COORD_W-1:0] y);
        point_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

endpackage

// File: rtl/body_scan_scheduler_frame_tick_gen.sv
// Free-running pixel counter over one LCD frame with a registered one-cycle
// frame_tick asserted while the count sits on the last pixel of the frame.
module body_scan_scheduler_frame_tick_gen
    import body_scan_scheduler_pkg::*;
#(
    parameter int H_PERIOD = FRAME_H_PERIOD,
    parameter int V_PERIOD = FRAME_V_PERIOD
) (
    input  logic lcd_screen_dclk,
    input  logic reset_n,
    output logic o_frame_tick
);

    localparam int FRAME_LEN = H_PERIOD * V_PERIOD;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(FRAME_LEN - 2);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;

    // Pixel counter; tick is raised one edge early so it is high exactly at the last count.
    always_ff @(posedge lcd_screen_dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_count == CNT_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
            r_tick <= (r_count == CNT_PRE_LAST);
        end
    end

    assign o_frame_tick = r_tick;

endmodule

// File: rtl/body_scan_scheduler.sv
// Streams a WINDOW-point slice of the snake body into a double-buffered window,
// one slice per LCD frame. Optional macro: BODY_SCAN_WRAP_EN (wrap short tails).
module body_scan_scheduler
    import body_scan_scheduler_pkg::*;
#(
    parameter int WINDOW   = 32,
    parameter int IDX_W    = 16,
    parameter int COORD_W  = POINT_COORD_W,
    parameter int H_PERIOD = FRAME_H_PERIOD,
    parameter int V_PERIOD = FRAME_V_PERIOD
) (
    input  logic                        lcd_screen_dclk,
    input  logic                        reset_n,
    input  logic [IDX_W-1:0]            snake_length,
    output logic [IDX_W-1:0]            seg_rd_idx,
    output logic                        seg_rd_en,
    input  logic [2*COORD_W-1:0]        seg_rd_data,
    output logic [WINDOW*2*COORD_W-1:0] window_points,
    output logic [WINDOW-1:0]           window_valid,
    output logic                        frame_tick,
    output logic                        loading
);

    localparam int PT_W = 2 * COORD_W;
    localparam int K_W  = $clog2(WINDOW);
    localparam int IW   = IDX_W + 1;
    localparam logic [IW-1:0]  ONE_IW = IW'(1);
    localparam logic [IW-1:0]  WIN_IW = IW'(WINDOW);
    localparam logic [K_W-1:0] K_LAST = K_W'(WINDOW - 1);

    if ((WINDOW < 2) || (WINDOW > 64) || ((WINDOW & (WINDOW - 1)) != 0)) begin : g_bad_window
        $error("body_scan_scheduler: WINDOW must be a power of two in 2..64");
    end
    if ((WINDOW + 2) >= (H_PERIOD * V_PERIOD)) begin : g_bad_frame
        $error("body_scan_scheduler: a load must finish within one frame");
    end

    // Index math runs one bit wider so base+WINDOW cannot wrap.
    function automatic logic [IW-1:0] advance_base(input logic [IW-1:0] base,
                                                   input logic [IW-1:0] len);
        logic [IW-1:0] w_res;
        if (len <= ONE_IW) begin
            w_res = ONE_IW;
        end else if ((base + WIN_IW) >= len) begin
            w_res = ONE_IW;
        end else begin
            w_res = base + WIN_IW;
        end
        return w_res;
    endfunction

    scan_state_t r_state, w_state_next;
    logic [IW-1:0]  r_len, w_len_next;
    logic [IW-1:0]  r_base, w_base_next;
    logic [IW-1:0]  r_idx, w_idx_next;
    logic [K_W-1:0] r_k, w_k_next;
    logic           w_issue, w_shadow_clr, w_commit;
    logic           r_rd_en, r_cap_en, r_loading;
    logic [IDX_W-1:0] r_rd_idx;
    logic [K_W-1:0]   r_cap_slot;
    logic [WINDOW*PT_W-1:0] r_shadow_pts, w_shadow_pts, r_win_pts;
    logic [WINDOW-1:0]      r_shadow_vld, w_shadow_vld, r_win_vld;
    logic                   w_frame_tick;

    body_scan_scheduler_frame_tick_gen #(
        .H_PERIOD (H_PERIOD),
        .V_PERIOD (V_PERIOD)
    ) u_frame_tick_gen (
        .lcd_screen_dclk (lcd_screen_dclk),
        .reset_n         (reset_n),
        .o_frame_tick    (w_frame_tick)
    );

    // Scan FSM next-state: a slot is presented on every cycle the next state is LOAD.
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_base_next  = r_base;
        w_k_next     = r_k;
        w_idx_next   = r_idx;
        w_issue      = 1'b0;
        w_shadow_clr = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_frame_tick) begin
                    w_state_next = LOAD;
                    w_len_next   = {1'b0, snake_length};
                    w_base_next  = advance_base(r_base, w_len_next);
                    w_k_next     = '0;
                    w_idx_next   = w_base_next;
                    w_shadow_clr = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOAD: begin
                if (r_k == K_LAST) begin
                    w_state_next = COMMIT;
                end else begin
                    w_k_next = r_k + K_W'(1);
`ifdef BODY_SCAN_WRAP_EN
                    w_idx_next = ((r_idx + ONE_IW) == r_len) ? ONE_IW : (r_idx + ONE_IW);
`else
                    w_idx_next = r_idx + ONE_IW;
`endif
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
                w_commit     = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_state_next == LOAD) begin
`ifdef BODY_SCAN_WRAP_EN
            w_issue = (w_len_next > ONE_IW);
`else
            w_issue = (w_idx_next < w_len_next);
`endif
        end else begin
            w_issue = 1'b0;
        end
    end

    // Scan control, read port and capture pipeline registers.
    always_ff @(posedge lcd_screen_dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_base     <= ONE_IW;
            r_idx      <= '0;
            r_k        <= '0;
            r_rd_en    <= 1'b0;
            r_rd_idx   <= '0;
            r_cap_en   <= 1'b0;
            r_cap_slot <= '0;
            r_loading  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_base     <= w_base_next;
            r_idx      <= w_idx_next;
            r_k        <= w_k_next;
            r_rd_en    <= w_issue;
            r_rd_idx   <= w_issue ? w_idx_next[IDX_W-1:0] : '0;
            r_cap_en   <= r_rd_en;
            r_cap_slot <= r_k;
            r_loading  <= (w_state_next != IDLE);
        end
    end

    // Shadow view including the read returning this cycle, so COMMIT sees the last slot.
    always_comb begin
        w_shadow_pts = r_shadow_pts;
        w_shadow_vld = r_shadow_vld;
        for (int i = 0; i < WINDOW; i++) begin
            if (r_cap_en && (r_cap_slot == K_W'(i))) begin
                w_shadow_pts[i*PT_W +: PT_W] = seg_rd_data;
                w_shadow_vld[i]              = 1'b1;
            end else begin
                w_shadow_vld[i] = r_shadow_vld[i];
            end
        end
    end

    // Shadow buffer fill and single-edge copy into the active window.
    always_ff @(posedge lcd_screen_dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_pts <= '0;
            r_shadow_vld <= '0;
            r_win_pts    <= '0;
            r_win_vld    <= '0;
        end else begin
            if (w_shadow_clr) begin
                r_shadow_pts <= '0;
                r_shadow_vld <= '0;
            end else begin
                r_shadow_pts <= w_shadow_pts;
                r_shadow_vld <= w_shadow_vld;
            end
            if (w_commit) begin
                r_win_pts <= w_shadow_pts;
                r_win_vld <= w_shadow_vld;
            end else begin
                r_win_pts <= r_win_pts;
                r_win_vld <= r_win_vld;
            end
        end
    end

    assign seg_rd_idx    = r_rd_idx;
    assign seg_rd_en     = r_rd_en;
    assign window_points = r_win_pts;
    assign window_valid  = r_win_vld;
    assign frame_tick    = w_frame_tick;
    assign loading       = r_loading;

endmodule

// File: tb/tb_body_scan_scheduler.sv
// Scoreboard bench for body_scan_scheduler: a frame-level model predicts reads and
// the committed window; independent monitors compare whenever the DUT presents them.
module tb_body_scan_scheduler;

    localparam int WINDOW   = 4;
    localparam int IDX_W    = 16;
    localparam int COORD_W  = 16;
    localparam int H_PERIOD = 4;
    localparam int V_PERIOD = 4;
    localparam int FRAME    = H_PERIOD * V_PERIOD;
    localparam int PT_W     = 2 * COORD_W;
    localparam int WW       = WINDOW * PT_W;

    logic                 lcd_screen_dclk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [IDX_W-1:0]     snake_length = 16'd10;
    logic [IDX_W-1:0]     seg_rd_idx;
    logic                 seg_rd_en;
    logic [PT_W-1:0]      seg_rd_data = 32'd0;
    logic [WW-1:0]        window_points;
    logic [WINDOW-1:0]    window_valid;
    logic                 frame_tick;
    logic                 loading;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WINDOW-1:0] vld;
        logic [WW-1:0]     pts;
        int                tick_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rd_q[$];
    int   cyc = 0;
    int   m_base = 1;
    bit   prev_loading = 1'b0;

    always #5 lcd_screen_dclk = ~lcd_screen_dclk;

    body_scan_scheduler #(
        .WINDOW   (WINDOW),
        .IDX_W    (IDX_W),
        .COORD_W  (COORD_W),
        .H_PERIOD (H_PERIOD),
        .V_PERIOD (V_PERIOD)
    ) u_dut (
        .lcd_screen_dclk (lcd_screen_dclk),
        .reset_n         (reset_n),
        .snake_length    (snake_length),
        .seg_rd_idx      (seg_rd_idx),
        .seg_rd_en       (seg_rd_en),
        .seg_rd_data     (seg_rd_data),
        .window_points   (window_points),
        .window_valid    (window_valid),
        .frame_tick      (frame_tick),
        .loading         (loading)
    );

    // Body array stub: one-cycle read latency, garbage when no read was issued.
    always @(posedge lcd_screen_dclk) begin
        if (seg_rd_en) seg_rd_data <= 32'(seg_rd_idx) * 32'h0001_0001;
        else           seg_rd_data <= $urandom;
    end

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: choose the base, then list the slots this frame shows.
    task automatic model_frame(input int len);
        exp_t e;
        int   idx;
        if (len <= 1 || m_base + WINDOW >= len) m_base = 1;
        else m_base = m_base + WINDOW;
        e.vld = '0;
        e.pts = '0;
        e.tick_cyc = cyc;
        for (int k = 0; k < WINDOW; k++) begin
`ifdef BODY_SCAN_WRAP_EN
            if (len >= 2) begin
                idx = 1 + ((m_base + k - 1) % (len - 1));
`else
            idx = m_base + k;
            if (idx < len) begin
`endif
                e.vld[k] = 1'b1;
                e.pts[k*PT_W +: PT_W] = 32'(idx) * 32'h0001_0001;
                rd_q.push_back(idx);
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: checks reads, tick phase, and the committed window on loading's fall.
    always @(negedge lcd_screen_dclk) begin
        if (!reset_n) begin
            cyc = 0;
            prev_loading = 1'b0;
            m_base = 1;
            exp_q.delete();
            rd_q.delete();
        end else begin
            if (seg_rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected_idx", WW'(seg_rd_idx), WW'(0));
                    chk("rd_unexpected_en", WW'(seg_rd_en), WW'(0));
                end else begin
                    chk("rd_idx", WW'(seg_rd_idx), WW'(rd_q.pop_front()));
                end
            end
            if (frame_tick) begin
                chk("tick_phase", WW'(cyc % FRAME), WW'(FRAME - 1));
                model_frame(int'(snake_length));
            end
            if (prev_loading && !loading) begin
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", WW'(1), WW'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("window_valid", WW'(window_valid), WW'(e.vld));
                    chk("window_points", window_points, e.pts);
                    chk("load_latency", WW'(cyc - e.tick_cyc), WW'(WINDOW + 2));
                    chk("reads_missing", WW'(rd_q.size()), WW'(0));
                    rd_q.delete();
                end
            end
            if (exp_q.size() > 0 && (cyc - exp_q[0].tick_cyc) > WINDOW + 8) begin
                chk("commit_timeout", WW'(cyc - exp_q[0].tick_cyc), WW'(WINDOW + 2));
                exp_q.delete();
                rd_q.delete();
            end
            prev_loading = loading;
            cyc++;
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge lcd_screen_dclk);
            n++;
        end while (!frame_tick && n < 4 * FRAME);
        if (!frame_tick) chk("tick_timeout", WW'(frame_tick), WW'(1));
    endtask

    task automatic set_len_after(input int edges, input int len);
        repeat (edges) @(posedge lcd_screen_dclk);
        #2 snake_length = IDX_W'(len);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_en"}, WW'(seg_rd_en), WW'(0));
        chk({tag, "_rd_idx"}, WW'(seg_rd_idx), WW'(0));
        chk({tag, "_points"}, window_points, WW'(0));
        chk({tag, "_valid"}, WW'(window_valid), WW'(0));
        chk({tag, "_loading"}, WW'(loading), WW'(0));
        chk({tag, "_tick"}, WW'(frame_tick), WW'(0));
    endtask

    initial begin
        repeat (3) @(posedge lcd_screen_dclk);
        #1 check_zero_outputs("reset");
        @(posedge lcd_screen_dclk);
        #2 reset_n = 1'b1;

        // length 10: bases 5, 9, 1 then length 7 lands on base 5
        repeat (3) wait_tick();
        set_len_after(1, 7);
        wait_tick();
        set_len_after(1, 1);
        wait_tick();
        set_len_after(1, 10);
        wait_tick();
        // length drops during a load; that load still uses the latched length
        wait_tick();
        set_len_after(2, 3);
        wait_tick();
        set_len_after(1, 10);

        // reset in LOAD cycle 2 aborts the load at once
        wait_tick();
        repeat (3) @(posedge lcd_screen_dclk);
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("abort");
        repeat (2) @(posedge lcd_screen_dclk);
        #2 reset_n = 1'b1;
        repeat (3) wait_tick();

        for (int f = 0; f < 30; f++) begin
            wait_tick();
            set_len_after($urandom_range(1, FRAME - 1), $urandom_range(0, 20));
        end

        for (int n = 0; n < 4 * FRAME && (loading || exp_q.size() != 0); n++) begin
            @(negedge lcd_screen_dclk);
        end
        @(negedge lcd_screen_dclk);
        chk("drain", WW'(exp_q.size()), WW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
